// File: rtl/final_adder_seq.sv
// Sliced carry-propagate adder resolving the Booth compressor carry/sum pair into the product.
// Optional carry-out port `_cout` is enabled by defining FINADD_COUT_EN.
module final_adder_seq #(
    parameter int WIDTH = 24,
    parameter int SLICE = 6
) (
    input  logic             _clk,
    input  logic             _rst,
    input  logic             _in_valid,
    output logic             _in_ready,
    input  logic [WIDTH-1:0] _C,
    input  logic [WIDTH-1:0] _S,
    output logic             _out_valid,
    input  logic             _out_ready,
    output logic [WIDTH-1:0] _P
`ifdef FINADD_COUT_EN
    ,
    output logic             _cout
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [SLICE:0]   sum;
    logic             last;
    int               base;
`ifdef FINADD_COUT_EN
    logic             cout_q, cout_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        idx_d   = idx_q;
        carry_d = carry_q;
`ifdef FINADD_COUT_EN
        cout_d  = cout_q;
`endif
        base = int'(idx_q) * SLICE;
        last = (idx_q == IDXW'(NSLICE - 1));
        sum  = {1'b0, a_q[base +: SLICE]}
             + {1'b0, b_q[base +: SLICE]}
             + {{SLICE{1'b0}}, carry_q};

        case (state_q)
            S_IDLE: begin
                if (_in_valid) begin
                    a_d     = _C;
                    b_d     = _S;
                    p_d     = '0;
                    idx_d   = '0;
                    carry_d = 1'b0;
`ifdef FINADD_COUT_EN
                    cout_d  = 1'b0;
`endif
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                p_d[base +: SLICE] = sum[SLICE-1:0];
                carry_d = sum[SLICE];
                // Index stops on the last slice instead of wrapping
                if (last) begin
                    state_d = S_DONE;
`ifdef FINADD_COUT_EN
                    cout_d  = sum[SLICE];
`endif
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                if (_out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge _clk) begin
        if (_rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
        end
    end

`ifdef FINADD_COUT_EN
    always_ff @(posedge _clk) begin
        if (_rst) cout_q <= 1'b0;
        else      cout_q <= cout_d;
    end
    assign _cout = cout_q;
`endif

    assign _in_ready  = (state_q == S_IDLE);
    assign _out_valid = (state_q == S_DONE);
    assign _P         = p_q;

endmodule

// File: tb/tb_final_adder_seq.sv
// Directed bench for final_adder_seq: default slicing plus a SLICE=WIDTH instance.
module tb_final_adder_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [23:0] c, s, p;
    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [23:0] c2, s2, p2;
`ifdef FINADD_COUT_EN
    logic        cout, cout2;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    final_adder_seq #(.WIDTH(24), .SLICE(6)) dut (
        ._clk(clk), ._rst(rst),
        ._in_valid(in_valid), ._in_ready(in_ready),
        ._C(c), ._S(s),
        ._out_valid(out_valid), ._out_ready(out_ready),
        ._P(p)
`ifdef FINADD_COUT_EN
        , ._cout(cout)
`endif
    );

    final_adder_seq #(.WIDTH(24), .SLICE(24)) dut24 (
        ._clk(clk), ._rst(rst),
        ._in_valid(in_valid2), ._in_ready(in_ready2),
        ._C(c2), ._S(s2),
        ._out_valid(out_valid2), ._out_ready(out_ready2),
        ._P(p2)
`ifdef FINADD_COUT_EN
        , ._cout(cout2)
`endif
    );

    // Accept one pair, scramble the inputs, count edges until out_valid
    task automatic op(input logic [23:0] cc, input logic [23:0] ss, output int lat);
        @(negedge clk);
        c = cc; s = ss; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; c = 24'hABCDEF; s = 24'h5A5A5A;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handoff;
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_cmp++;
        if (p !== 24'h0) begin
            n_fail++; $display("FAIL reset_p got %h want 000000", p);
        end
`ifdef FINADD_COUT_EN
        n_cmp++;
        if (cout !== 1'b0) begin
            n_fail++; $display("FAIL reset_cout got %b want 0", cout);
        end
`endif
    endtask

    task automatic test_ripple;
        int lat;
        op(24'h000002, 24'h000FFF, lat);
        n_cmp++;
        if (lat != 4) begin
            n_fail++; $display("FAIL ripple_latency got %0d want 4", lat);
        end
        n_cmp++;
        if (p !== 24'h001001) begin
            n_fail++; $display("FAIL ripple_p got %h want 001001", p);
        end
        handoff();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ripple_handoff got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_full_carry;
        int lat;
        op(24'h000002, 24'hFFFFFF, lat);
        n_cmp++;
        if (p !== 24'h000001 || lat != 4) begin
            n_fail++; $display("FAIL full_carry_p got %h lat %0d want 000001 lat 4", p, lat);
        end
`ifdef FINADD_COUT_EN
        n_cmp++;
        if (cout !== 1'b1) begin
            n_fail++; $display("FAIL full_carry_cout got %b want 1", cout);
        end
`endif
        handoff();
    endtask

    task automatic test_signed;
        int lat;
        op(24'h000000, 24'hFFFFDD, lat);
        n_cmp++;
        if (p !== 24'hFFFFDD) begin
            n_fail++; $display("FAIL signed_neg35 got %h want FFFFDD", p);
        end
`ifdef FINADD_COUT_EN
        n_cmp++;
        if (cout !== 1'b0) begin
            n_fail++; $display("FAIL signed_cout got %b want 0", cout);
        end
`endif
        handoff();
        op(24'h000456, 24'h000123, lat);
        n_cmp++;
        if (p !== 24'h000579) begin
            n_fail++; $display("FAIL signed_pos got %h want 000579", p);
        end
        handoff();
    endtask

    task automatic test_backpressure;
        int lat;
        op(24'h000111, 24'h000222, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (p !== 24'h000333 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got p=%h vld=%b rdy=%b want 000333 1 0",
                         i, p, out_valid, in_ready);
            end
            in_valid = (i % 2 == 0);
            c = 24'h00F00F;
            s = 24'h0F00F0;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 24'h000333) begin
            n_fail++;
            $display("FAIL bp_release got rdy=%b vld=%b p=%h want 1 0 000333",
                     in_ready, out_valid, p);
        end
    endtask

    task automatic test_reset_mid_add;
        int lat;
        @(negedge clk);
        c = 24'h0000AA; s = 24'h000055; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (p !== 24'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_add_reset got p=%h vld=%b rdy=%b want 000000 0 1",
                     p, out_valid, in_ready);
        end
        op(24'h000020, 24'h000010, lat);
        n_cmp++;
        if (p !== 24'h000030 || lat != 4) begin
            n_fail++; $display("FAIL post_reset_op got %h lat %0d want 000030 lat 4", p, lat);
        end
        handoff();
    endtask

    task automatic test_back_to_back;
        int cyc;
        int first;
        int second;
        cyc = 0; first = -1; second = -1;
        @(negedge clk);
        c = 24'h000001; s = 24'h000002;
        in_valid = 1'b1; out_ready = 1'b1;
        while (second < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (second - first != 6 || first != 5) begin
            n_fail++;
            $display("FAIL b2b_spacing got first=%0d second=%0d want 5 11", first, second);
        end
        n_cmp++;
        if (p !== 24'h000003) begin
            n_fail++; $display("FAIL b2b_p got %h want 000003", p);
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_idle got %b want 1", in_ready);
        end
    endtask

    task automatic test_slice24;
        int lat;
        @(negedge clk);
        c2 = 24'h000002; s2 = 24'h7FFFFF; in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0; c2 = 24'h111111; s2 = 24'h222222;
        lat = 0;
        while (!out_valid2 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat != 1) begin
            n_fail++; $display("FAIL slice24_latency got %0d want 1", lat);
        end
        n_cmp++;
        if (p2 !== 24'h800001) begin
            n_fail++; $display("FAIL slice24_p got %h want 800001", p2);
        end
        @(negedge clk);
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        n_cmp++;
        if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL slice24_handoff got rdy=%b vld=%b want 1 0", in_ready2, out_valid2);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; c = '0; s = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; c2 = '0; s2 = '0;
        test_reset();
        test_ripple();
        test_full_carry();
        test_signed();
        test_backpressure();
        test_reset_mid_add();
        test_back_to_back();
        test_slice24();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
